// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory access controller.
//   - request size encodings (SZ_B/SZ_H/SZ_W/SZ_D)
//   - controller state enum (IDLE/LOAD/RMW/WRITE/RESP)
//   - misaligned(): alignment check of a byte offset for a given size
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RMW   = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
   } state_t;

   // A request is misaligned when its byte offset is not a multiple of its size.
   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offs);
      logic m;
      case (size)
         SZ_B:    m = 1'b0;
         SZ_H:    m = offs[0];
         SZ_W:    m = (offs[1:0] != 2'b00);
         SZ_D:    m = (offs != 3'b000);
         default: m = 1'b1;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane logic for 64-bit little-endian words.
// Ports:
//   word        in  64  current memory word
//   wdata       in  64  right-aligned store data
//   lane        in  3   byte offset inside the word
//   size        in  2   access size (SZ_B..SZ_D)
//   is_unsigned in  1   1 = zero-extend loads, 0 = sign-extend
//   load_data   out 64  selected lane, extended to 64 bits
//   merged      out 64  word with the selected lane replaced by wdata's low bytes
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [63:0] word,
   input  logic [63:0] wdata,
   input  logic [2:0]  lane,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [63:0] load_data,
   output logic [63:0] merged
);

   logic [2:0]  lane_eff;
   logic [63:0] lane_mask;
   logic [63:0] shifted;
   logic [63:0] mask_sh;
   logic [63:0] wdata_sh;
   logic        sign;

   // Lane select, load extension and store merge.
   always_comb begin
      lane_eff  = 3'b000;
      lane_mask = 64'h0;
      load_data = 64'h0;
      sign      = 1'b0;
      // Low offset bits are ignored per size so a stray bit can never
      // shift a half/word across the word boundary.
      case (size)
         SZ_B: begin
            lane_eff  = lane;
            lane_mask = 64'h0000_0000_0000_00FF;
         end
         SZ_H: begin
            lane_eff  = {lane[2:1], 1'b0};
            lane_mask = 64'h0000_0000_0000_FFFF;
         end
         SZ_W: begin
            lane_eff  = {lane[2], 2'b00};
            lane_mask = 64'h0000_0000_FFFF_FFFF;
         end
         SZ_D: begin
            lane_eff  = 3'b000;
            lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
         end
         default: begin
            lane_eff  = 3'b000;
            lane_mask = 64'h0;
         end
      endcase

      shifted = word >> {lane_eff, 3'b000};

      case (size)
         SZ_B: begin
            sign      = ~is_unsigned & shifted[7];
            load_data = {{56{sign}}, shifted[7:0]};
         end
         SZ_H: begin
            sign      = ~is_unsigned & shifted[15];
            load_data = {{48{sign}}, shifted[15:0]};
         end
         SZ_W: begin
            sign      = ~is_unsigned & shifted[31];
            load_data = {{32{sign}}, shifted[31:0]};
         end
         SZ_D: begin
            sign      = 1'b0;
            load_data = shifted;
         end
         default: begin
            sign      = 1'b0;
            load_data = 64'h0;
         end
      endcase

      mask_sh  = lane_mask << {lane_eff, 3'b000};
      wdata_sh = wdata << {lane_eff, 3'b000};
      merged   = (word & ~mask_sh) | (wdata_sh & mask_sh);
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences byte-addressed load/store requests onto a
// 64-bit word-addressed memory (single write enable, combinational read).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we/req_size/req_unsigned    store flag, size, zero-extend flag
//   req_addr/req_wdata              byte address, right-aligned store data
//   rsp_valid/rsp_rdata/rsp_err     one-cycle response pulse with data / error
//   mem_addr/mem_we/mem_din         memory word index, write enable, write data
//   mem_dout                        memory read data for mem_addr
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int BITS      = 64,
   parameter int DEPTH     = 32,
   parameter int ADDR_BITS = 8
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [1:0]           req_size,
   input  logic                 req_unsigned,
   input  logic [ADDR_BITS-1:0] req_addr,
   input  logic [BITS-1:0]      req_wdata,
   output logic                 rsp_valid,
   output logic [BITS-1:0]      rsp_rdata,
   output logic                 rsp_err,
   output logic [ADDR_BITS-4:0] mem_addr,
   output logic                 mem_we,
   output logic [BITS-1:0]      mem_din,
   input  logic [BITS-1:0]      mem_dout
);

   localparam int IDX_BITS = $clog2(DEPTH);

   state_t          state;
   logic [2:0]      lane_q;
   logic [1:0]      size_q;
   logic            uns_q;
   logic [BITS-1:0] wdata_q;
   logic [BITS-1:0] load_ext;
   logic [BITS-1:0] merged;

   dmem_lane_align u_align (
      .word        (mem_dout),
      .wdata       (wdata_q),
      .lane        (lane_q),
      .size        (size_q),
      .is_unsigned (uns_q),
      .load_data   (load_ext),
      .merged      (merged)
   );

   // Request sequencing FSM; every output is a register of this block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= {BITS{1'b0}};
         rsp_err   <= 1'b0;
         mem_addr  <= {(ADDR_BITS-3){1'b0}};
         mem_we    <= 1'b0;
         mem_din   <= {BITS{1'b0}};
         lane_q    <= 3'b000;
         size_q    <= SZ_B;
         uns_q     <= 1'b0;
         wdata_q   <= {BITS{1'b0}};
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  mem_addr  <= req_addr[IDX_BITS+2:3];
                  lane_q    <= req_addr[2:0];
                  size_q    <= req_size;
                  uns_q     <= req_unsigned;
                  wdata_q   <= req_wdata;
                  req_ready <= 1'b0;
                  if (misaligned(req_size, req_addr[2:0])) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= {BITS{1'b0}};
                  end else if (!req_we) begin
                     state <= LOAD;
                  end else if (req_size == SZ_D) begin
                     // Full-word store needs no read, so it skips RMW.
                     state   <= WRITE;
                     mem_we  <= 1'b1;
                     mem_din <= req_wdata;
                  end else begin
                     state <= RMW;
                  end
               end else begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end
            end
            LOAD: begin
               rsp_rdata <= load_ext;
               rsp_err   <= 1'b0;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RMW: begin
               mem_din <= merged;
               mem_we  <= 1'b1;
               state   <= WRITE;
            end
            WRITE: begin
               mem_we    <= 1'b0;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= {BITS{1'b0}};
               state     <= RESP;
            end
            RESP: begin
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= {BITS{1'b0}};
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               mem_we    <= 1'b0;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= {BITS{1'b0}};
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed table-driven bench for dmem_access_ctrl with a
// behavioural 32x64 memory attached to the memory port.
module tb_dmem_access_ctrl;
   import dmem_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [7:0]  req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   logic [4:0]  mem_addr;
   logic        mem_we;
   logic [63:0] mem_din;
   logic [63:0] mem_dout;

   logic [63:0] mem [0:31];
   logic        preload;

   int checks = 0;
   int errors = 0;

   dmem_access_ctrl #(.BITS(64), .DEPTH(32), .ADDR_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_din(mem_din), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   assign mem_dout = mem[mem_addr];

   // Memory model: preload image while preload is high, else synchronous write.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) mem[i] <= 64'h0;
         mem[0] <= 64'h30;
         mem[1] <= 64'h14;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_din;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   // Issue one request at a negedge and observe until its response.
   // lat = edges from accept to the rsp_valid cycle (99 when no response arrives).
   task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [7:0] addr, input logic [63:0] wd,
                          output int lat, output logic [63:0] rd, output logic er,
                          output int wec, output logic [63:0] din);
      int n;
      bit got;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 99; rd = 64'h0; er = 1'b0; wec = 0; din = 64'h0; got = 1'b0;
      for (int k = 1; k <= 10 && !got; k++) begin
         if (mem_we) begin
            wec++;
            din = mem_din;
         end
         if (rsp_valid) begin
            lat = k; rd = rsp_rdata; er = rsp_err; got = 1'b1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   typedef struct {
      string       name;
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [7:0]  addr;
      logic [63:0] wd;
      int          lat;
      logic [63:0] rd;
      logic        er;
      int          wec;
      logic [63:0] din;
   } vec_t;

   vec_t vecs[16];

   int          lat, wec, acc, nrsp, nwe, busy_rdy;
   logic [63:0] rd, din;
   logic        er, busy, accept_now;
   logic [63:0] rsp_q[2];

   initial begin
      vecs[0]  = '{"ld_d_08",  1'b0, SZ_D, 1'b0, 8'h08, 64'h0, 2, 64'h14, 1'b0, 0, 64'h0};
      vecs[1]  = '{"sb_01",    1'b1, SZ_B, 1'b0, 8'h01, 64'hAB, 3, 64'h0, 1'b0, 1, 64'hAB30};
      vecs[2]  = '{"ld_d_00",  1'b0, SZ_D, 1'b0, 8'h00, 64'h0, 2, 64'hAB30, 1'b0, 0, 64'h0};
      vecs[3]  = '{"lb_01",    1'b0, SZ_B, 1'b0, 8'h01, 64'h0, 2, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 0, 64'h0};
      vecs[4]  = '{"lbu_01",   1'b0, SZ_B, 1'b1, 8'h01, 64'h0, 2, 64'hAB, 1'b0, 0, 64'h0};
      vecs[5]  = '{"lh_00",    1'b0, SZ_H, 1'b0, 8'h00, 64'h0, 2, 64'hFFFF_FFFF_FFFF_AB30, 1'b0, 0, 64'h0};
      vecs[6]  = '{"sh_03_mis",1'b1, SZ_H, 1'b0, 8'h03, 64'hFFFF, 1, 64'h0, 1'b1, 0, 64'h0};
      vecs[7]  = '{"sd_0c_mis",1'b1, SZ_D, 1'b0, 8'h0C, 64'hDEAD, 1, 64'h0, 1'b1, 0, 64'h0};
      vecs[8]  = '{"lw_12_mis",1'b0, SZ_W, 1'b0, 8'h12, 64'h0, 1, 64'h0, 1'b1, 0, 64'h0};
      vecs[9]  = '{"sd_10",    1'b1, SZ_D, 1'b0, 8'h10, 64'h0123_4567_89AB_CDEF, 2, 64'h0, 1'b0, 1, 64'h0123_4567_89AB_CDEF};
      vecs[10] = '{"lw_14",    1'b0, SZ_W, 1'b0, 8'h14, 64'h0, 2, 64'h0123_4567, 1'b0, 0, 64'h0};
      vecs[11] = '{"lw_10",    1'b0, SZ_W, 1'b0, 8'h10, 64'h0, 2, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 0, 64'h0};
      vecs[12] = '{"sh_16",    1'b1, SZ_H, 1'b0, 8'h16, 64'h1111_BEEF, 3, 64'h0, 1'b0, 1, 64'hBEEF_4567_89AB_CDEF};
      vecs[13] = '{"lhu_16",   1'b0, SZ_H, 1'b1, 8'h16, 64'h0, 2, 64'hBEEF, 1'b0, 0, 64'h0};
      vecs[14] = '{"lb_13",    1'b0, SZ_B, 1'b0, 8'h13, 64'h0, 2, 64'hFFFF_FFFF_FFFF_FF89, 1'b0, 0, 64'h0};
      vecs[15] = '{"lwu_10",   1'b0, SZ_W, 1'b1, 8'h10, 64'h0, 2, 64'h89AB_CDEF, 1'b0, 0, 64'h0};

      clk = 1'b0; rst_n = 1'b0; preload = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = SZ_B; req_unsigned = 1'b0;
      req_addr = 8'h0; req_wdata = 64'h0;

      // Reset state.
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_ready", {63'h0, req_ready}, 64'h1);
      chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
      chk("rst_rsp_err", {63'h0, rsp_err}, 64'h0);
      chk("rst_rsp_rdata", rsp_rdata, 64'h0);
      chk("rst_mem_we", {63'h0, mem_we}, 64'h0);
      chk("rst_mem_addr", {59'h0, mem_addr}, 64'h0);
      chk("rst_mem_din", mem_din, 64'h0);
      @(negedge clk);
      preload = 1'b0;
      rst_n = 1'b1;

      // Directed vector table.
      for (int v = 0; v < 16; v++) begin
         run_req(vecs[v].we, vecs[v].sz, vecs[v].uns, vecs[v].addr, vecs[v].wd,
                 lat, rd, er, wec, din);
         chk({vecs[v].name, "_lat"}, 64'(lat), 64'(vecs[v].lat));
         chk({vecs[v].name, "_rdata"}, rd, vecs[v].rd);
         chk({vecs[v].name, "_err"}, {63'h0, er}, {63'h0, vecs[v].er});
         chk({vecs[v].name, "_wecnt"}, 64'(wec), 64'(vecs[v].wec));
         chk({vecs[v].name, "_din"}, din, vecs[v].din);
      end
      chk("mem0_after", mem[0], 64'hAB30);
      chk("mem1_after_err", mem[1], 64'h14);
      chk("mem2_after", mem[2], 64'hBEEF_4567_89AB_CDEF);

      // Held req_valid with SW then LW to the same word.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_unsigned = 1'b0;
      req_addr = 8'h0C; req_wdata = 64'h1234_5678;
      acc = 0; nrsp = 0; nwe = 0; busy_rdy = 0; busy = 1'b0;
      rsp_q[0] = 64'hX; rsp_q[1] = 64'hX;
      for (int c = 0; c < 30 && nrsp < 2; c++) begin
         if (busy && req_ready) busy_rdy++;
         accept_now = req_valid && req_ready;
         @(posedge clk);
         #1;
         if (accept_now) begin
            acc++;
            busy = 1'b1;
            if (acc == 1) req_we = 1'b0;
            else req_valid = 1'b0;
         end
         if (mem_we) nwe++;
         if (rsp_valid) begin
            if (nrsp < 2) rsp_q[nrsp] = rsp_rdata;
            nrsp++;
            busy = 1'b0;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("hold_accepts", 64'(acc), 64'd2);
      chk("hold_responses", 64'(nrsp), 64'd2);
      chk("hold_write_cycles", 64'(nwe), 64'd1);
      chk("hold_ready_while_busy", 64'(busy_rdy), 64'd0);
      chk("hold_sw_rdata", rsp_q[0], 64'h0);
      chk("hold_lw_rdata", rsp_q[1], 64'h1234_5678);
      chk("hold_mem1", mem[1], 64'h1234_5678_0000_0014);

      // Reset during the WRITE cycle of a byte store.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = SZ_B; req_unsigned = 1'b0;
      req_addr = 8'h18; req_wdata = 64'h55;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("rstmid_we_before", {63'h0, mem_we}, 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_we_drop", {63'h0, mem_we}, 64'h0);
      chk("rstmid_rsp_valid", {63'h0, rsp_valid}, 64'h0);
      chk("rstmid_ready", {63'h0, req_ready}, 64'h1);
      chk("rstmid_mem_addr", {59'h0, mem_addr}, 64'h0);
      chk("rstmid_mem_din", mem_din, 64'h0);
      chk("rstmid_rdata", rsp_rdata, 64'h0);
      chk("rstmid_err", {63'h0, rsp_err}, 64'h0);
      nrsp = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (rsp_valid) nrsp++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (rsp_valid) nrsp++;
      end
      chk("rstmid_no_rsp", 64'(nrsp), 64'd0);
      chk("rstmid_mem3", mem[3], 64'h0);

      run_req(1'b0, SZ_D, 1'b0, 8'h18, 64'h0, lat, rd, er, wec, din);
      chk("post_rst_ld_lat", 64'(lat), 64'd2);
      chk("post_rst_ld_rdata", rd, 64'h0);
      run_req(1'b1, SZ_B, 1'b0, 8'h1B, 64'h77, lat, rd, er, wec, din);
      chk("post_rst_sb_lat", 64'(lat), 64'd3);
      chk("post_rst_sb_din", din, 64'h7700_0000);
      run_req(1'b0, SZ_B, 1'b1, 8'h0C, 64'h0, lat, rd, er, wec, din);
      chk("post_rst_lbu_rdata", rd, 64'h78);
      chk("post_rst_mem3", mem[3], 64'h7700_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
